combi_dmem: RTL and testbench
=============================

Name: combi_dmem

Overview:
- Data-memory responder on the load/store side of the combi RISC-V/ARM core: word-organised RAM with byte-enable writes and a request/ready handshake with a configurable wait-state count.
- Also decodes a memory-mapped result register: a store to RESULT_ADDR latches the program's final answer and raises a sticky flag that lets benches and top-levels detect test completion without snooping the bus.
- Tracks completed stores and flags illegal accesses.

Parameters:
- DEPTH, 64, number of 32-bit words; byte address range 0 .. 4*DEPTH-1.
- WAIT_CYCLES, 1, wait states between request acceptance and ready (0..15).
- RESULT_ADDR, 100, byte address of the result register (word aligned).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- req  input  1  access request, held until ready.
- we  input  1  1 = store, 0 = load; sampled with req.
- addr  input  32  byte address; sampled with req.
- wdata  input  32  store data; sampled with req.
- be  input  4  byte enables, be[i] covers wdata[8i+7:8i]; sampled with req.
- rdata  output  32  load data, valid only while ready=1.
- ready  output  1  one-cycle completion pulse.
- result_valid  output  1  sticky; set by the first store to RESULT_ADDR.
- result_data  output  32  wdata of the most recent store to RESULT_ADDR.
- err  output  1  sticky; misaligned or out-of-range access seen.
- store_count  output  16  saturating count of completed stores.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, ready=0, rdata=0, result_valid=0, result_data=0, err=0, store_count=0, wait counter=0.
  - RAM contents are not reset.
  - A reset mid-access aborts it; no write is performed.
- FSM IDLE:
  - req=1 latches we/addr/wdata/be.
  - Next state is WAIT when WAIT_CYCLES>0, otherwise RESP.
  - ready=0.
- FSM WAIT:
  - Counter loads WAIT_CYCLES-1 on entry and decrements each cycle.
  - Moves to RESP when the counter is 0.
  - Input changes are ignored.
- FSM RESP:
  - ready=1 for exactly one cycle, then IDLE.
  - Latency from the req-sampling edge to ready high is WAIT_CYCLES+1 cycles.
- Back-to-back accesses:
  - The requester deasserts req in the cycle after ready.
  - req still high in IDLE is a new access; no zero-gap back-to-back.
- Stores, performed on the clock edge that ends RESP:
  - Only enabled bytes are written.
  - store_count increments and saturates at 16'hFFFF.
- Loads:
  - rdata = RAM word at addr[31:2] during RESP.
  - rdata = 0 outside RESP.
- Result register (store with addr==RESULT_ADDR):
  - Also writes RAM.
  - result_data takes the full wdata regardless of be.
  - result_valid is set and stays 1 until reset.
- Illegal access: addr[1:0]!=0 or addr>=4*DEPTH.
  - Still completes with ready after normal latency.
  - Stores are dropped and store_count is not incremented.
  - Loads return 0.
  - err is set on the RESP edge.
- be=0 store: completes, counts as a store, RAM unchanged.
- A store then a load to the same address returns the new data (the write lands before the next access can be sampled).

Test Plan:
- Reset with WAIT_CYCLES=1: store 32'hDEADBEEF to 0, be=4'hF, then load from 0 -> ready exactly 2 cycles after each req sample, rdata=32'hDEADBEEF, store_count=1, err=0.
- Byte enables: store 32'h11223344 to 8 with be=4'hF, then 32'hAABBCCDD with be=4'b0101, load 8 -> rdata=32'h11BB33DD.
- Completion: store 7 to 96, then 25 to 100 -> result_valid rises on the RESP edge of the second store, result_data=25, store_count=2, load of 100 returns 25.
- Illegal access: store to 102 and load from 256 (DEPTH=64) -> both see ready, err=1 sticky, load rdata=0, store_count unchanged, word at 100 unchanged.
- Reset mid-access with WAIT_CYCLES=3: store 32'h55 to 4, assert reset in WAIT -> all outputs 0 immediately, no ready, later load of 4 returns the prior content.
- Latency sweep with WAIT_CYCLES=0 and 15: ready at 1 and 16 cycles after req sample.
- Saturation: store_count preset by 65540 stores -> holds 16'hFFFF.

Source files
------------

// File: rtl/combi_dmem.sv
// Data-memory responder for the combi core: byte-enable word RAM behind a
// req/ready handshake with WAIT_CYCLES wait states, plus a sticky result register.
module combi_dmem #(
  parameter int          DEPTH       = 64,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] RESULT_ADDR = 32'd100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        result_valid,
  output logic [31:0] result_data,
  output logic        err,
  output logic [15:0] store_count,
  output logic [1:0]  state
);

  // Handshake: the requester raises req with we/addr/wdata/be and holds it until
  // ready; ready is a one-cycle pulse and req must be low in the following cycle,
  // otherwise a request still high in IDLE starts a new access.
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      cur;
  state_t      nxt;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        legal;
  logic        do_store;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH];

  assign state    = cur;
  assign legal    = (addr_q[1:0] == 2'b00) && (addr_q < MEM_BYTES);
  assign idx      = addr_q[AW+1:2];
  assign do_store = (cur == S_RESP) && we_q && legal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur <= S_IDLE;
    end else begin
      cur <= nxt;
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE: if (req) nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (cnt == 4'd0) nxt = S_RESP;
      S_RESP: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    rdata = 32'd0;
    if (cur == S_RESP) begin
      ready = 1'b1;
      if (!we_q && legal) rdata = mem[idx];
    end
  end

  // Request fields are captured once in IDLE; later bus changes cannot disturb the access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      cnt     <= 4'd0;
    end else begin
      if (cur == S_IDLE && req) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
        be_q    <= be;
        cnt     <= WAIT_LOAD;
      end else if (cur == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_valid <= 1'b0;
      result_data  <= 32'd0;
      err          <= 1'b0;
      store_count  <= 16'd0;
    end else begin
      if (do_store && addr_q == RESULT_ADDR) begin
        result_valid <= 1'b1;
        result_data  <= wdata_q;
      end
      if (do_store && store_count != 16'hFFFF) store_count <= store_count + 16'd1;
      if (cur == S_RESP && !legal) err <= 1'b1;
    end
  end

  // RAM is not reset; a reset forces IDLE so an aborted access never writes.
  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_combi_dmem.sv
// Bench for combi_dmem: four instances with WAIT_CYCLES 1, 3, 0 and 15, driven
// from a vector table plus hand-written reset, latency and saturation sequences.
module tb_combi_dmem;

  logic        clk;
  logic        rst_v          [4];
  logic        req_v          [4];
  logic        we_v           [4];
  logic [31:0] addr_v         [4];
  logic [31:0] wdata_v        [4];
  logic [3:0]  be_v           [4];
  logic [31:0] rdata_v        [4];
  logic        ready_v        [4];
  logic        result_valid_v [4];
  logic [31:0] result_data_v  [4];
  logic        err_v          [4];
  logic [15:0] store_count_v  [4];
  logic [1:0]  state_v        [4];

  int n_vec = 0;
  int n_bad = 0;

  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      combi_dmem #(
        .DEPTH       (64),
        .WAIT_CYCLES ((g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 0 : 15),
        .RESULT_ADDR (32'd100)
      ) u_dut (
        .clk          (clk),
        .reset        (rst_v[g]),
        .req          (req_v[g]),
        .we           (we_v[g]),
        .addr         (addr_v[g]),
        .wdata        (wdata_v[g]),
        .be           (be_v[g]),
        .rdata        (rdata_v[g]),
        .ready        (ready_v[g]),
        .result_valid (result_valid_v[g]),
        .result_data  (result_data_v[g]),
        .err          (err_v[g]),
        .store_count  (store_count_v[g]),
        .state        (state_v[g])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  b;
    logic [31:0] exp_rd;
    logic [15:0] exp_cnt;
    logic        exp_err;
    logic        exp_rv;
    logic [31:0] exp_res;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One complete access on instance d; returns load data and latency in cycles
  // from the req-sampling edge. Bus fields are scrambled while waiting.
  task automatic do_access(input int d, input logic w, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] b,
                           output logic [31:0] rd, output int lat);
    logic done;
    @(negedge clk);
    req_v[d] = 1'b1; we_v[d] = w; addr_v[d] = a; wdata_v[d] = wd; be_v[d] = b;
    @(posedge clk);
    lat = 0; rd = 32'd0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      lat++;
      we_v[d]    = 1'($urandom_range(0, 1));
      addr_v[d]  = $urandom;
      wdata_v[d] = $urandom;
      be_v[d]    = 4'($urandom_range(0, 15));
      if (ready_v[d]) begin
        rd = rdata_v[d];
        done = 1'b1;
        req_v[d] = 1'b0;
      end
    end
    req_v[d] = 1'b0;
    if (!done) begin
      n_vec++; n_bad++;
      $display("FAIL timeout: no ready on instance %0d, expected within 40 cycles", d);
      lat = -1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("ready_pulse", 32'(ready_v[d]), 32'd0);
    chk("rdata_idle", rdata_v[d], 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    int          hits;
    logic [15:0] exp_cnt;

    tbl[0]  = '{1'b1, 32'd0,   32'hDEADBEEF, 4'hF, 32'h0,        16'd1, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'd0,   32'h0,        4'hF, 32'hDEADBEEF, 16'd1, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 32'd8,   32'h11223344, 4'hF, 32'h0,        16'd2, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 32'd8,   32'hAABBCCDD, 4'h5, 32'h0,        16'd3, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 32'd8,   32'h0,        4'hF, 32'h11BB33DD, 16'd3, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 32'd96,  32'd7,        4'hF, 32'h0,        16'd4, 1'b0, 1'b0, 32'h0};
    tbl[6]  = '{1'b1, 32'd100, 32'd25,       4'hF, 32'h0,        16'd5, 1'b0, 1'b1, 32'd25};
    tbl[7]  = '{1'b0, 32'd100, 32'h0,        4'hF, 32'd25,       16'd5, 1'b0, 1'b1, 32'd25};
    tbl[8]  = '{1'b1, 32'd102, 32'hFFFFFFFF, 4'hF, 32'h0,        16'd5, 1'b1, 1'b1, 32'd25};
    tbl[9]  = '{1'b0, 32'd256, 32'h0,        4'hF, 32'h0,        16'd5, 1'b1, 1'b1, 32'd25};
    tbl[10] = '{1'b0, 32'd100, 32'h0,        4'hF, 32'd25,       16'd5, 1'b1, 1'b1, 32'd25};
    tbl[11] = '{1'b1, 32'd8,   32'h12345678, 4'h0, 32'h0,        16'd6, 1'b1, 1'b1, 32'd25};
    tbl[12] = '{1'b0, 32'd8,   32'h0,        4'hF, 32'h11BB33DD, 16'd6, 1'b1, 1'b1, 32'd25};
    tbl[13] = '{1'b1, 32'd100, 32'hCAFE0030, 4'h1, 32'h0,        16'd7, 1'b1, 1'b1, 32'hCAFE0030};
    tbl[14] = '{1'b0, 32'd100, 32'h0,        4'hF, 32'h00000030, 16'd7, 1'b1, 1'b1, 32'hCAFE0030};
    tbl[15] = '{1'b0, 32'd96,  32'h0,        4'hF, 32'd7,        16'd7, 1'b1, 1'b1, 32'hCAFE0030};
    tbl[16] = '{1'b0, 32'd2,   32'h0,        4'hF, 32'h0,        16'd7, 1'b1, 1'b1, 32'hCAFE0030};

    // clock/reset
    for (int d = 0; d < 4; d++) begin
      rst_v[d] = 1'b0; req_v[d] = 1'b0; we_v[d] = 1'b0;
      addr_v[d] = 32'd0; wdata_v[d] = 32'd0; be_v[d] = 4'd0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) rst_v[d] = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk("rst_ready", 32'(ready_v[d]), 32'd0);
      chk("rst_rdata", rdata_v[d], 32'd0);
      chk("rst_result_valid", 32'(result_valid_v[d]), 32'd0);
      chk("rst_result_data", result_data_v[d], 32'd0);
      chk("rst_err", 32'(err_v[d]), 32'd0);
      chk("rst_store_count", 32'(store_count_v[d]), 32'd0);
    end

    // table-driven vectors on the WAIT_CYCLES=1 instance
    for (int i = 0; i < 17; i++) begin
      do_access(0, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].b, rd, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
      if (!tbl[i].w) chk($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("v%0d_store_count", i), 32'(store_count_v[0]), 32'(tbl[i].exp_cnt));
      chk($sformatf("v%0d_err", i), 32'(err_v[0]), 32'(tbl[i].exp_err));
      chk($sformatf("v%0d_result_valid", i), 32'(result_valid_v[0]), 32'(tbl[i].exp_rv));
      chk($sformatf("v%0d_result_data", i), result_data_v[0], tbl[i].exp_res);
    end

    // latency sweep: WAIT_CYCLES=0 and 15, store then load back
    do_access(2, 1'b1, 32'd16, 32'hA5A55A5A, 4'hF, rd, lat);
    chk("w0_store_latency", 32'(lat), 32'd1);
    do_access(2, 1'b0, 32'd16, 32'd0, 4'hF, rd, lat);
    chk("w0_load_latency", 32'(lat), 32'd1);
    chk("w0_load_data", rd, 32'hA5A55A5A);
    do_access(3, 1'b1, 32'd20, 32'h0BADF00D, 4'hF, rd, lat);
    chk("w15_store_latency", 32'(lat), 32'd16);
    do_access(3, 1'b0, 32'd20, 32'd0, 4'hF, rd, lat);
    chk("w15_load_latency", 32'(lat), 32'd16);
    chk("w15_load_data", rd, 32'h0BADF00D);

    // reset in the middle of a WAIT_CYCLES=3 store
    do_access(1, 1'b1, 32'd4, 32'h12345678, 4'hF, rd, lat);
    chk("w3_latency", 32'(lat), 32'd4);
    chk("w3_count_before", 32'(store_count_v[1]), 32'd1);
    @(negedge clk);
    req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 32'd4; wdata_v[1] = 32'h55; be_v[1] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    chk("w3_in_wait_ready", 32'(ready_v[1]), 32'd0);
    rst_v[1] = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready_v[1]), 32'd0);
    chk("midrst_rdata", rdata_v[1], 32'd0);
    chk("midrst_store_count", 32'(store_count_v[1]), 32'd0);
    chk("midrst_err", 32'(err_v[1]), 32'd0);
    chk("midrst_result_valid", 32'(result_valid_v[1]), 32'd0);
    chk("midrst_result_data", result_data_v[1], 32'd0);
    chk("midrst_state_idle", 32'(state_v[1]), 32'd0);
    req_v[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst_v[1] = 1'b1;
    hits = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ready_v[1]) hits++;
    end
    chk("midrst_no_ready", 32'(hits), 32'd0);
    do_access(1, 1'b0, 32'd4, 32'd0, 4'hF, rd, lat);
    chk("midrst_prior_content", rd, 32'h12345678);
    chk("midrst_count_after", 32'(store_count_v[1]), 32'd0);

    // saturation: preload the counter near the top, then keep storing
    @(negedge clk);
    force g_dut[2].u_dut.store_count = 16'hFFFB;
    @(negedge clk);
    release g_dut[2].u_dut.store_count;
    exp_cnt = 16'hFFFB;
    for (int k = 0; k < 6; k++) begin
      do_access(2, 1'b1, 32'd24, 32'(k), 4'hF, rd, lat);
      exp_cnt = (exp_cnt == 16'hFFFF) ? 16'hFFFF : exp_cnt + 16'd1;
      chk($sformatf("sat_count_%0d", k), 32'(store_count_v[2]), 32'(exp_cnt));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
